// File: rtl/game_select_ctrl.sv
// Game & Watch console scheduler: menu FSM, core enable gating, button routing, VGA mux and LFSR.
// Define GAME_SELECT_HISCORE_EN to keep per-game high-score registers; otherwise HiScore is 0.
`timescale 1ns / 1ps

module game_select_ctrl #(
  parameter int unsigned NGAMES = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Up,
  input  logic                  Down,
  input  logic                  Esc,
  input  logic                  Enter,
  input  logic                  MenuCol,
  input  logic [NGAMES-1:0]     GameCol,
  input  logic [NGAMES-1:0]     GameQuit,
  input  logic [10*NGAMES-1:0]  GameScore,
  output logic [NGAMES-1:0]     GameEnable,
  output logic                  GameUp,
  output logic                  GameDown,
  output logic                  GameEsc,
  output logic                  GameEnter,
  output logic                  VGAcol,
  output logic [SEL_W-1:0]      Selection,
  output logic [9:0]            HiScore,
  output logic [15:0]           Rand,
  output logic                  InGame
);

  typedef enum logic [1:0] {
    StMenu,
    StLaunch,
    StPlay,
    StDrain
  } state_t;

  localparam logic [SEL_W-1:0] LastSel  = SEL_W'(NGAMES - 1);
  localparam logic [15:0]      RandSeed = 16'hACE1;
  localparam logic [15:0]      RandMask = 16'hB400;

  state_t            state;
  logic              up_d, down_d, enter_d;
  logic              rise_up, rise_down, rise_enter;
  logic              any_btn;
  logic [SEL_W-1:0]  sel_eff;
  logic [NGAMES-1:0] sel_onehot;
  logic              quit_sel;

  // An out-of-range index can only appear if forced; it behaves as game 0.
  assign sel_eff    = (32'(Selection) < NGAMES) ? Selection : '0;
  assign sel_onehot = NGAMES'(1) << sel_eff;
  assign quit_sel   = GameQuit[sel_eff];

  assign rise_up    = Up & ~up_d;
  assign rise_down  = Down & ~down_d;
  assign rise_enter = Enter & ~enter_d;
  assign any_btn    = Up | Down | Esc | Enter;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= StMenu;
      Selection  <= '0;
      GameEnable <= '0;
      InGame     <= 1'b0;
      // History starts high so a button held through reset produces no edge.
      up_d       <= 1'b1;
      down_d     <= 1'b1;
      enter_d    <= 1'b1;
    end else begin
      up_d    <= Up;
      down_d  <= Down;
      enter_d <= Enter;
      case (state)
        StMenu: begin
          if (rise_enter) begin
            state <= StLaunch;
          end else if (rise_up && !rise_down) begin
            Selection <= (sel_eff == '0) ? LastSel : sel_eff - SEL_W'(1);
          end else if (rise_down && !rise_up) begin
            Selection <= (sel_eff == LastSel) ? '0 : sel_eff + SEL_W'(1);
          end
        end
        StLaunch: begin
          // Core stays in reset until every button is released.
          if (!any_btn) begin
            state      <= StPlay;
            GameEnable <= sel_onehot;
            InGame     <= 1'b1;
          end
        end
        StPlay: begin
          if (quit_sel) begin
            state      <= StDrain;
            GameEnable <= '0;
            InGame     <= 1'b0;
          end
        end
        StDrain: begin
          if (!any_btn) begin
            state <= StMenu;
          end
        end
        default: begin
          state      <= StMenu;
          GameEnable <= '0;
          InGame     <= 1'b0;
        end
      endcase
    end
  end

  assign GameUp    = InGame & Up;
  assign GameDown  = InGame & Down;
  assign GameEsc   = InGame & Esc;
  assign GameEnter = InGame & Enter;
  assign VGAcol    = InGame ? GameCol[sel_eff] : MenuCol;

  // Galois LFSR, shift right with feedback from bit 0; period 65535, never zero.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Rand <= RandSeed;
    end else begin
      Rand <= (Rand >> 1) ^ (Rand[0] ? RandMask : 16'h0000);
    end
  end

`ifdef GAME_SELECT_HISCORE_EN
  logic [9:0] hi_score [NGAMES];
  logic [9:0] cur_score;

  assign cur_score = GameScore[10*sel_eff +: 10];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < int'(NGAMES); i++) begin
        hi_score[i] <= '0;
      end
    end else if (state == StPlay && quit_sel && cur_score > hi_score[sel_eff]) begin
      hi_score[sel_eff] <= cur_score;
    end
  end

  assign HiScore = hi_score[sel_eff];
`else
  logic unused_score;
  assign unused_score = ^GameScore;
  assign HiScore      = 10'd0;
`endif

endmodule

// File: tb/tb_game_select_ctrl.sv
// Directed self-checking bench for game_select_ctrl (NGAMES=3).
`timescale 1ns / 1ps

module tb_game_select_ctrl;

`ifdef GAME_SELECT_HISCORE_EN
  localparam bit HsEn = 1'b1;
`else
  localparam bit HsEn = 1'b0;
`endif

  logic        Clock, Reset, Up, Down, Esc, Enter, MenuCol;
  logic [2:0]  GameCol, GameQuit, GameEnable;
  logic [29:0] GameScore;
  logic        GameUp, GameDown, GameEsc, GameEnter, VGAcol, InGame;
  logic [1:0]  Selection;
  logic [9:0]  HiScore;
  logic [15:0] Rand;

  int n_cmp = 0;
  int n_bad = 0;

  game_select_ctrl #(
    .NGAMES (3),
    .SEL_W  (2)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Up         (Up),
    .Down       (Down),
    .Esc        (Esc),
    .Enter      (Enter),
    .MenuCol    (MenuCol),
    .GameCol    (GameCol),
    .GameQuit   (GameQuit),
    .GameScore  (GameScore),
    .GameEnable (GameEnable),
    .GameUp     (GameUp),
    .GameDown   (GameDown),
    .GameEsc    (GameEsc),
    .GameEnter  (GameEnter),
    .VGAcol     (VGAcol),
    .Selection  (Selection),
    .HiScore    (HiScore),
    .Rand       (Rand),
    .InGame     (InGame)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  function automatic logic [31:0] hs(input int v);
    return HsEn ? 32'(v) : 32'd0;
  endfunction

  task automatic pulse_down();
    Down = 1'b1; step(1); Down = 1'b0; step(1);
  endtask

  task automatic pulse_up();
    Up = 1'b1; step(1); Up = 1'b0; step(1);
  endtask

  // Launch the selected game, quit it with the given score, return to the menu.
  task automatic play_and_quit(input int score);
    Enter = 1'b1; step(1); Enter = 1'b0; step(1);
    check("replay_ingame", 32'(InGame), 32'd1);
    GameScore[19:10] = 10'(score);
    GameQuit = 3'b010; step(1); GameQuit = 3'b000;
    check("replay_quit_en", 32'(GameEnable), 32'd0);
    step(1);
  endtask

  int zero_seen;
  int early_wrap;

  initial begin
    Reset = 1'b1; Up = 1'b0; Down = 1'b1; Esc = 1'b0; Enter = 1'b0; MenuCol = 1'b0;
    GameCol = 3'b000; GameQuit = 3'b000; GameScore = '0;
    step(2);
    check("rst_sel", 32'(Selection), 32'd0);
    check("rst_en", 32'(GameEnable), 32'd0);
    check("rst_ingame", 32'(InGame), 32'd0);
    check("rst_gdown", 32'(GameDown), 32'd0);
    check("rst_rand", 32'(Rand), 32'hACE1);
    check("rst_hi", 32'(HiScore), 32'd0);

    // Down held through reset must not step the selection.
    Reset = 1'b0;
    check("rand0", 32'(Rand), 32'hACE1);
    step(1);
    check("rand1", 32'(Rand), 32'hE270);
    step(1);
    check("rand2", 32'(Rand), 32'h7138);
    check("held_down_no_edge", 32'(Selection), 32'd0);
    Down = 1'b0; step(1);

    pulse_down(); check("down1", 32'(Selection), 32'd1);
    pulse_down(); check("down2", 32'(Selection), 32'd2);
    pulse_down(); check("down_wrap", 32'(Selection), 32'd0);
    pulse_up();   check("up_wrap", 32'(Selection), 32'd2);
    Up = 1'b1; Down = 1'b1; step(1); Up = 1'b0; Down = 1'b0; step(1);
    check("up_down_same", 32'(Selection), 32'd2);
    Esc = 1'b1; step(1); Esc = 1'b0; step(1);
    check("esc_menu", 32'(Selection), 32'd2);
    Down = 1'b1; step(100); Down = 1'b0; step(1);
    check("hold_down", 32'(Selection), 32'd0);
    pulse_down(); check("sel1", 32'(Selection), 32'd1);

    // Launch game 1 with Enter held for 5 cycles.
    Enter = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("launch_en", 32'(GameEnable), 32'd0);
      check("launch_ingame", 32'(InGame), 32'd0);
    end
    Enter = 1'b0; step(1);
    check("play_en", 32'(GameEnable), 32'b010);
    check("play_ingame", 32'(InGame), 32'd1);
    GameCol = 3'b010; MenuCol = 1'b0; #1;
    check("vga_game1", 32'(VGAcol), 32'd1);
    GameCol = 3'b101; MenuCol = 1'b1; #1;
    check("vga_game0", 32'(VGAcol), 32'd0);
    Up = 1'b1; #1;
    check("gup_hi", 32'(GameUp), 32'd1);
    Up = 1'b0; #1;
    check("gup_lo", 32'(GameUp), 32'd0);
    pulse_down();
    check("play_sel_frozen", 32'(Selection), 32'd1);

    GameQuit = 3'b100; step(2); GameQuit = 3'b000;
    check("foreign_quit_ingame", 32'(InGame), 32'd1);
    check("foreign_quit_en", 32'(GameEnable), 32'b010);

    GameScore[19:10] = 10'd37; Esc = 1'b1; #1;
    check("gesc_play", 32'(GameEsc), 32'd1);
    GameQuit = 3'b010; step(1); GameQuit = 3'b000;
    check("drain_en", 32'(GameEnable), 32'd0);
    check("drain_ingame", 32'(InGame), 32'd0);
    check("drain_gesc", 32'(GameEsc), 32'd0);
    check("drain_vga", 32'(VGAcol), 32'd1);
    step(3);
    check("drain_hold", 32'(GameEnable), 32'd0);
    Esc = 1'b0; step(1);
    check("menu_sel", 32'(Selection), 32'd1);
    check("hi37", 32'(HiScore), hs(37));

    play_and_quit(12); check("hi_after12", 32'(HiScore), hs(37));
    play_and_quit(37); check("hi_after37", 32'(HiScore), hs(37));
    play_and_quit(38); check("hi_after38", 32'(HiScore), hs(38));
    pulse_up();   check("sel0_hi", 32'(HiScore), 32'd0);
    pulse_down(); check("sel1_hi", 32'(HiScore), hs(38));

    // Enter wins over a simultaneous Down edge.
    Enter = 1'b1; Down = 1'b1; step(1); Enter = 1'b0; Down = 1'b0; step(1);
    check("enter_prio_en", 32'(GameEnable), 32'b010);
    check("enter_prio_sel", 32'(Selection), 32'd1);

    Reset = 1'b1; step(1);
    check("midrst_en", 32'(GameEnable), 32'd0);
    check("midrst_ingame", 32'(InGame), 32'd0);
    check("midrst_sel", 32'(Selection), 32'd0);
    check("midrst_hi0", 32'(HiScore), 32'd0);
    Reset = 1'b0; step(1);
    pulse_down(); check("midrst_hi1", 32'(HiScore), 32'd0);

    // Full LFSR period from the seed.
    Reset = 1'b1; step(1); Reset = 1'b0;
    check("rand_seed", 32'(Rand), 32'hACE1);
    zero_seen = 0;
    early_wrap = 0;
    for (int i = 1; i <= 65535; i++) begin
      step(1);
      if (Rand == 16'h0000) zero_seen++;
      if (Rand == 16'hACE1 && i < 65535) early_wrap++;
    end
    check("rand_zero", 32'(zero_seen), 32'd0);
    check("rand_early", 32'(early_wrap), 32'd0);
    check("rand_period", 32'(Rand), 32'hACE1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_select_ctrl.md
Name: game_select_ctrl

Overview:
- Top-level scheduler for the Game & Watch console: menu FSM choosing one of NGAMES game cores (octopus-style modules with Enable/Quit/Score/VGAcol).
- Gates each core's Enable, routes buttons to the active core only, muxes the 1-bit VGA colour between menu ROM and active core, tracks per-game high score.
- Supplies the shared 16-bit pseudo-random word to all cores.

Parameters:
- NGAMES, 3, number of attached game cores (2..4)
- SEL_W, 2, width of selection index; 2^SEL_W >= NGAMES

Ports:
- Clock  input  1  system clock
- Reset  input  1  reset, synchronous, active-high
- Up  input  1  raw button
- Down  input  1  raw button
- Esc  input  1  raw button
- Enter  input  1  raw button
- MenuCol  input  1  pixel colour from menu sprite ROM
- GameCol  input  NGAMES  pixel colour per core, bit i = core i
- GameQuit  input  NGAMES  Quit per core
- GameScore  input  10*NGAMES  Score per core, core i at [10i+9:10i]
- GameEnable  output  NGAMES  one-hot Enable per core; all-zero holds cores in reset
- GameUp  output  1  Up routed to the active core
- GameDown  output  1  Down routed to the active core
- GameEsc  output  1  Esc routed to the active core
- GameEnter  output  1  Enter routed to the active core
- VGAcol  output  1  selected pixel colour
- Selection  output  SEL_W  highlighted or running game index
- HiScore  output  10  high score of the game at Selection
- Rand  output  16  LFSR value shared by cores
- InGame  output  1  high in PLAY state

Behaviour:
- States: MENU, LAUNCH, PLAY, DRAIN. Reset -> MENU.
- Reset values:
  - Selection=0, GameEnable=0, Game* buttons=0, InGame=0.
  - All high scores = 0; Rand = 16'hACE1.
  - Edge-detect history registers = 1, so buttons held through reset give no edge.
- Edge detect: rise_X = X & ~X_d, X_d registered each cycle. Used only in MENU.
- MENU:
  - rise_Up: Selection = (Selection==0) ? NGAMES-1 : Selection-1.
  - rise_Down: Selection = (Selection==NGAMES-1) ? 0 : Selection+1.
  - rise_Up and rise_Down in the same cycle: no change.
  - rise_Enter -> LAUNCH (takes priority over Up/Down in the same cycle).
  - Esc is ignored in MENU.
- LAUNCH:
  - GameEnable stays 0, so the target core sees ~Enable and resets.
  - Stays until Up|Down|Esc|Enter are all 0 for one sampled cycle -> PLAY. Minimum residency 1 cycle.
- PLAY:
  - GameEnable = 1<<Selection, registered; asserted the cycle after entering PLAY.
  - Game* buttons = raw buttons, combinational pass-through.
  - Selection is frozen.
  - GameQuit[Selection]==1 -> DRAIN, with high-score update the same edge (see below).
  - Quit from non-selected cores is ignored.
- DRAIN:
  - GameEnable=0, Game* buttons=0.
  - Waits until all four buttons are released -> MENU.
- High-score update (on PLAY->DRAIN edge): if GameScore[Selection] > hi[Selection] (10-bit unsigned), hi[Selection] = GameScore[Selection]; equal scores leave it unchanged.
- HiScore = hi[Selection], combinational.
- VGAcol = InGame ? GameCol[Selection] : MenuCol, combinational.
- InGame: 1 exactly while state==PLAY.
- Rand:
  - Advances every cycle in all states (Galois LFSR, mask 16'hB400, shift right, feedback from bit 0). Never reaches 0.
  - Held at 16'hACE1 while Reset.
- Reset mid-PLAY: GameEnable drops the next edge, state MENU, high scores cleared.
- Selection >= NGAMES is unreachable; if forced, treat as 0.

Optional Feature:
- Macro: GAME_SELECT_HISCORE_EN.
- Defined: per-game high-score registers and the update rule above.
- Undefined: no high-score registers; HiScore tied to 10'd0; state transitions unchanged.

Test Plan:
- Reset, then 3 Down pulses with NGAMES=3 -> Selection 0->1->2->0; then 1 Up pulse -> Selection 2. Holding Down for 100 cycles gives exactly one step.
- Selection=1, press and hold Enter 5 cycles -> LAUNCH with GameEnable=000 while held; release -> 1 cycle later PLAY, GameEnable=010, InGame=1, VGAcol follows GameCol[1].
- In PLAY on game 1, toggle Up -> GameUp mirrors it the same cycle; GameScore[1]=37, pulse GameQuit[1] -> next edge GameEnable=000, state DRAIN; with buttons released -> MENU; HiScore=37 at Selection=1.
- Replay game 1 and quit with score 12 -> HiScore stays 37. Quit with 37 -> unchanged. Quit with 38 -> HiScore=38. Selection=0 -> HiScore=0.
- GameQuit[2] asserted while playing game 1 -> no state change. Reset asserted mid-PLAY -> next edge GameEnable=000, MENU, Selection=0, HiScore=0.
- Rand after reset release: 16'hACE1, then 16'hE270, then 16'h7138; never 0 over 65535 cycles; period 65535.
